// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Per-key synchroniser, debounce FSM and short/long press
//                classifier. Emits single-cycle, registered event pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int NUM_KEYS     = 2,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] short_press,
  output logic [NUM_KEYS-1:0] long_press
);

  localparam int DC_W = $clog2(DEBOUNCE_CYC);
  localparam int HC_W = $clog2(LONG_CYC);

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYC - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(LONG_CYC - 1);

  // Raw pin level that corresponds to a released key.
  localparam logic [NUM_KEYS-1:0] REL_LEVEL = {NUM_KEYS{ACTIVE_LOW}};

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DB_PRESS = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_DB_REL   = 2'd3;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] w_pressed;

  // Two-flop synchroniser; resets to the released level so a key held
  // through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= REL_LEVEL;
      r_sync2 <= REL_LEVEL;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Normalise polarity: 1 means pressed from here on.
  assign w_pressed = r_sync2 ^ REL_LEVEL;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic            w_p;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [DC_W-1:0] r_dc;
    logic [DC_W-1:0] w_dc_nxt;
    logic [HC_W-1:0] r_hc;
    logic [HC_W-1:0] w_hc_nxt;
    logic            r_lf;
    logic            w_lf_nxt;

    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_short;
    logic            r_long;
    logic            w_level_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_short_nxt;
    logic            w_long_nxt;

    assign w_p = w_pressed[k];

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_dc      <= '0;
        r_hc      <= '0;
        r_lf      <= 1'b0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_short   <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_dc      <= w_dc_nxt;
        r_hc      <= w_hc_nxt;
        r_lf      <= w_lf_nxt;
        r_level   <= w_level_nxt;
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_short   <= w_short_nxt;
        r_long    <= w_long_nxt;
      end
    end

    // Next state and counter updates; counters saturate at their last value.
    always_comb begin
      w_state_nxt = r_state;
      w_dc_nxt    = r_dc;
      w_hc_nxt    = r_hc;
      w_lf_nxt    = r_lf;
      case (r_state)
        S_IDLE: begin
          if (w_p) begin
            w_state_nxt = S_DB_PRESS;
            w_dc_nxt    = '0;
          end
        end
        S_DB_PRESS: begin
          if (!w_p) begin
            w_state_nxt = S_IDLE;
          end else if (r_dc == DC_LAST) begin
            w_state_nxt = S_HELD;
            w_hc_nxt    = '0;
            w_lf_nxt    = 1'b0;
          end else begin
            w_dc_nxt = r_dc + 1'b1;
          end
        end
        S_HELD: begin
          // A release edge wins over the long threshold; hc is held.
          if (!w_p) begin
            w_state_nxt = S_DB_REL;
            w_dc_nxt    = '0;
          end else if (!r_lf) begin
            if (r_hc == HC_LAST) begin
              w_lf_nxt = 1'b1;
            end else begin
              w_hc_nxt = r_hc + 1'b1;
            end
          end
        end
        S_DB_REL: begin
          // hc and lf are frozen here so a bounce only delays long_press.
          if (w_p) begin
            w_state_nxt = S_HELD;
          end else if (r_dc == DC_LAST) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_dc_nxt = r_dc + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    // Output decode, computed one cycle early and registered above.
    always_comb begin
      w_level_nxt   = (w_state_nxt == S_HELD) || (w_state_nxt == S_DB_REL);
      w_press_nxt   = (r_state == S_DB_PRESS) && w_p && (r_dc == DC_LAST);
      w_release_nxt = (r_state == S_DB_REL) && !w_p && (r_dc == DC_LAST);
      w_short_nxt   = w_release_nxt && !r_lf;
      w_long_nxt    = (r_state == S_HELD) && w_p && !r_lf && (r_hc == HC_LAST);
    end

    assign key_state[k]   = r_level;
    assign key_press[k]   = r_press;
    assign key_release[k] = r_release;
    assign short_press[k] = r_short;
    assign long_press[k]  = r_long;
  end

endmodule
`default_nettype wire
